// File: rtl/reg_file_8x16_pkg.sv
// Shared constants and helpers for the 8x16 register file with a one-entry write stage.
package reg_file_8x16_pkg;

  localparam int RF_WIDTH  = 16;
  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 3;

  typedef logic [RF_ADDR_W-1:0] addr_t;

  function automatic logic [RF_DEPTH-1:0] addr_onehot(input addr_t addr);
    logic [RF_DEPTH-1:0] dec;
    dec = '0;
    dec[addr] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/reg_file_8x16_if.sv
// Write/read bus of the register file; the master drives requests, the slave returns read data.
interface reg_file_8x16_if
  import reg_file_8x16_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
);

  logic             WE;
  addr_t            WA;
  logic [WIDTH-1:0] D;
  addr_t            QA;
  addr_t            QB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             PEND;

  modport master (
    output WE, WA, D, QA, QB,
    input  A, B, PEND
  );

  modport slave (
    input  WE, WA, D, QA, QB,
    output A, B, PEND
  );

endinterface

// File: rtl/reg_file_8x16_read_mux8.sv
// 8-to-1 combinational read selector over the register array.
module read_mux8
  import reg_file_8x16_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic [RF_DEPTH-1:0][WIDTH-1:0] regs,
  input  addr_t                          sel,
  output logic [WIDTH-1:0]               data
);

  always_comb begin
    data = '0;
    unique case (sel)
      3'd0: data = regs[0];
      3'd1: data = regs[1];
      3'd2: data = regs[2];
      3'd3: data = regs[3];
      3'd4: data = regs[4];
      3'd5: data = regs[5];
      3'd6: data = regs[6];
      3'd7: data = regs[7];
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_8x16.sv
// Register file with a one-entry write stage: capture on edge N, commit on edge N+1,
// staged data forwarded to both combinational read ports in the meantime.
module reg_file_8x16
  import reg_file_8x16_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH
) (
  input logic           CLK,
  input logic           RESET_N,
  reg_file_8x16_if.slave bus
);

  logic                       vld_p1;
  addr_t                      wa_p1;
  logic [WIDTH-1:0]           d_p1;
  logic [DEPTH-1:0][WIDTH-1:0] regs_p2;
  logic [DEPTH-1:0]           we_dec;
  logic [WIDTH-1:0]           arr_a;
  logic [WIDTH-1:0]           arr_b;

  // Stage p1: write capture. Only the valid flag needs reset; data is qualified by it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) vld_p1 <= 1'b0;
    else          vld_p1 <= bus.WE;
  end

  always_ff @(posedge CLK) begin
    if (bus.WE) begin
      wa_p1 <= bus.WA;
      d_p1  <= bus.D;
    end
  end

  // Stage p2: commit into the array through a one-hot decode of the staged address.
  always_comb begin
    we_dec = '0;
    if (vld_p1) we_dec = addr_onehot(wa_p1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs_p2 <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_dec[i]) regs_p2[i] <= d_p1;
      end
    end
  end

  read_mux8 #(.WIDTH(WIDTH)) u_mux_a (
    .regs (regs_p2),
    .sel  (bus.QA),
    .data (arr_a)
  );

  read_mux8 #(.WIDTH(WIDTH)) u_mux_b (
    .regs (regs_p2),
    .sel  (bus.QB),
    .data (arr_b)
  );

  // Forwarding only ever looks at the sampled stage, never at the raw WA/D inputs.
  always_comb begin
    bus.A = arr_a;
    bus.B = arr_b;
    if (vld_p1 && (wa_p1 == bus.QA)) bus.A = d_p1;
    if (vld_p1 && (wa_p1 == bus.QB)) bus.B = d_p1;
  end

  assign bus.PEND = vld_p1;

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed scoreboard bench for reg_file_8x16: reset, latency, forwarding and streaming.
module tb_reg_file_8x16;
  import reg_file_8x16_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  reg_file_8x16_if #(.WIDTH(16)) bus ();

  reg_file_8x16 #(.WIDTH(16), .DEPTH(8)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string name, input logic [15:0] a, input logic [15:0] b, input logic pend);
    exp_t e;
    e.name = name; e.a = a; e.b = b; e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic write_commit(input logic [2:0] addr, input logic [15:0] data);
    bus.WE = 1'b1; bus.WA = addr; bus.D = data;
    tick();
    bus.WE = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      bus.QA = 3'(i); bus.QB = 3'(7 - i);
      push("reset_init", 16'h0000, 16'h0000, 1'b0);
      #1;
      e = sb.pop_front(); checks++;
      if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
        errors++;
        $display("FAIL %s[%0d]: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, i, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
      end
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    write_commit(3'd1, 16'h1234);
    bus.WE = 1'b1; bus.WA = 3'd6; bus.D = 16'hABCD;
    tick();
    #2;
    RESET_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.QA = 3'(i); bus.QB = 3'(7 - i);
      push("reset_mid", 16'h0000, 16'h0000, 1'b0);
      #1;
      e = sb.pop_front(); checks++;
      if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
        errors++;
        $display("FAIL %s[%0d]: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, i, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
      end
    end
    @(negedge CLK);
    bus.WA = 3'd7; bus.D = 16'h7777;
    RESET_N = 1'b1;
    tick();
    bus.WE = 1'b0;
    bus.QA = 3'd7; bus.QB = 3'd6;
    push("reset_first_capture", 16'h7777, 16'h0000, 1'b1);
    #1;
    e = sb.pop_front(); checks++;
    if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
      errors++;
      $display("FAIL %s: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
    end
    tick();
    bus.QA = 3'd1; bus.QB = 3'd6;
    push("reset_staged_lost", 16'h0000, 16'h0000, 1'b0);
    #1;
    e = sb.pop_front(); checks++;
    if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
      errors++;
      $display("FAIL %s: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
    end
  endtask

  task automatic test_write_latency();
    exp_t e;
    write_commit(3'd3, 16'h1111);
    bus.WE = 1'b1; bus.WA = 3'd3; bus.D = 16'hBEEF; bus.QA = 3'd3; bus.QB = 3'd3;
    push("lat_before_edge", 16'h1111, 16'h1111, 1'b0);
    push("lat_edge1", 16'hBEEF, 16'hBEEF, 1'b1);
    push("lat_edge2", 16'hBEEF, 16'hBEEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin
        tick();
        bus.WE = 1'b0;
      end
      #1;
      e = sb.pop_front(); checks++;
      if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
        errors++;
        $display("FAIL %s: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus.WE = 1'b1; bus.WA = 3'd5; bus.D = 16'h0001; bus.QA = 3'd5; bus.QB = 3'd5;
    tick();
    bus.D = 16'h0002;
    push("b2b_edge1", 16'h0001, 16'h0001, 1'b1);
    push("b2b_edge2", 16'h0002, 16'h0002, 1'b1);
    push("b2b_edge3", 16'h0002, 16'h0002, 1'b0);
    push("b2b_edge4", 16'h0002, 16'h0002, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        tick();
        bus.WE = 1'b0;
      end
      #1;
      e = sb.pop_front(); checks++;
      if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
        errors++;
        $display("FAIL %s: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
      end
    end
  endtask

  task automatic test_streaming();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      bus.WE = 1'b1; bus.WA = 3'(i); bus.D = 16'h1000 + 16'(i);
      tick();
      bus.QA = 3'(i);
      bus.QB = (i == 0) ? 3'd0 : 3'(i - 1);
      push("stream_fwd", 16'h1000 + 16'(i), (i == 0) ? 16'h1000 : 16'h1000 + 16'(i - 1), 1'b1);
      #1;
      e = sb.pop_front(); checks++;
      if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
        errors++;
        $display("FAIL %s[%0d]: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, i, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
      end
    end
    bus.WE = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.QA = 3'(i); bus.QB = 3'(7 - i);
      push("stream_read", 16'h1000 + 16'(i), 16'h1000 + 16'(7 - i), 1'b0);
      #1;
      e = sb.pop_front(); checks++;
      if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
        errors++;
        $display("FAIL %s[%0d]: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, i, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
      end
    end
  endtask

  task automatic test_dual_forward();
    exp_t e;
    write_commit(3'd2, 16'h00AA);
    bus.WE = 1'b1; bus.WA = 3'd2; bus.D = 16'h0055; bus.QA = 3'd2; bus.QB = 3'd2;
    push("dual_before_edge", 16'h00AA, 16'h00AA, 1'b0);
    push("dual_fwd", 16'h0055, 16'h0055, 1'b1);
    push("dual_other_reg", 16'h1004, 16'h0055, 1'b1);
    push("dual_committed", 16'h0055, 16'h0055, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        tick();
        bus.WE = 1'b0;
      end else if (k == 2) begin
        bus.QA = 3'd4;
      end else if (k == 3) begin
        tick();
        bus.QA = 3'd2;
      end
      #1;
      e = sb.pop_front(); checks++;
      if ({bus.A, bus.B, bus.PEND} !== {e.a, e.b, e.pend}) begin
        errors++;
        $display("FAIL %s: got A=%h B=%h PEND=%b, want A=%h B=%h PEND=%b", e.name, bus.A, bus.B, bus.PEND, e.a, e.b, e.pend);
      end
    end
  endtask

  initial begin
    bus.WE = 1'b0; bus.WA = '0; bus.D = '0; bus.QA = '0; bus.QB = '0;
    test_reset();
    test_write_latency();
    test_back_to_back();
    test_streaming();
    test_dual_forward();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
